// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencing controller
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    // Instruction word loaded into IF/ID when ifid_flush is asserted (addi x0,x0,0)
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        STACK    = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard status in / pipeline register controls out
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs_a;
    logic [REG_W-1:0] id_rs_b;
    logic             id_rs_a_used;
    logic             id_rs_b_used;
    logic [REG_W-1:0] ex_dest;
    logic             ex_mem_read;
    logic             ex_call;
    logic             ex_ret;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_bubble;

    modport master (
        output id_rs_a, id_rs_b, id_rs_a_used, id_rs_b_used, ex_dest, ex_mem_read,
               ex_call, ex_ret, ex_redirect, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, exmem_bubble
    );

    modport slave (
        input  id_rs_a, id_rs_b, id_rs_a_used, id_rs_b_used, ex_dest, ex_mem_read,
               ex_call, ex_ret, ex_redirect, mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, exmem_bubble
    );

endinterface

// File: rtl/pipe_hazard_cmp.sv
// rtl/pipe_hazard_cmp.sv - combinational load-use hazard detector (also used by forwarding checks)
module pipe_hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_dest_i,
    input  logic [REG_W-1:0] rs_a_i,
    input  logic             rs_a_used_i,
    input  logic [REG_W-1:0] rs_b_i,
    input  logic             rs_b_used_i,
    output logic             hazard_o
);

    assign hazard_o = ex_mem_read_i && (ex_dest_i != '0) &&
                      ((rs_a_used_i && (rs_a_i == ex_dest_i)) ||
                       (rs_b_used_i && (rs_b_i == ex_dest_i)));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline enable/flush/bubble sequencer; PIPE_CTRL_PERF_EN adds stall/flush counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STACK_LAT = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_if.slave       bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam logic [3:0] STK_INIT = (STACK_LAT > 1) ? 4'(STACK_LAT - 2) : 4'd0;

    if (STACK_LAT < 1 || STACK_LAT > 15 || CNT_W < 1) begin : g_bad_param
        $error("pipe_ctrl: STACK_LAT must be 1..15 and CNT_W >= 1");
    end

    ctrl_state_e state_q, state_d;
    logic [3:0]  stk_cnt_q, stk_cnt_d;
    logic        hazard;
    logic        mem_wait;
    logic        pc_en, ifid_en, idex_en, exmem_en;
    logic        ifid_flush, idex_bubble, exmem_bubble;

    pipe_hazard_cmp u_hazard (
        .ex_mem_read_i (bus.ex_mem_read),
        .ex_dest_i     (bus.ex_dest),
        .rs_a_i        (bus.id_rs_a),
        .rs_a_used_i   (bus.id_rs_a_used),
        .rs_b_i        (bus.id_rs_b),
        .rs_b_used_i   (bus.id_rs_b_used),
        .hazard_o      (hazard)
    );

    assign mem_wait = bus.mem_req && !bus.mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            stk_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            stk_cnt_q <= stk_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stk_cnt_d    = stk_cnt_q;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;

        if (mem_wait) begin
            // A stack op stalled by memory stays in STACK so its count resumes afterwards
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            if (state_q != STACK) begin
                state_d = MEM_WAIT;
            end
        end else if (state_q == STACK) begin
            if (stk_cnt_q == 4'd0) begin
                state_d = RUN;
                if (bus.ex_ret || bus.ex_redirect) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
            end else begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_bubble = 1'b1;
                stk_cnt_d    = stk_cnt_q - 4'd1;
            end
        end else begin
            state_d = RUN;
            if ((bus.ex_call || bus.ex_ret) && (STACK_LAT > 1)) begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_bubble = 1'b1;
                stk_cnt_d    = STK_INIT;
                state_d      = STACK;
            end else if (bus.ex_redirect || bus.ex_ret) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (hazard) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end
        end

        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.ifid_en      = ifid_en;
    assign bus.idex_en      = idex_en;
    assign bus.exmem_en     = exmem_en;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_bubble  = idex_bubble;
    assign bus.exmem_bubble = exmem_bubble;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (ifid_flush && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed vector bench for pipe_ctrl (STACK_LAT=3; CNT_W=2 when PIPE_CTRL_PERF_EN)
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [1:0] stall_cycles, flush_count;
    pipe_ctrl #(.STACK_LAT(3), .CNT_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );
`else
    pipe_ctrl #(.STACK_LAT(3), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`endif

    always #5 clk = ~clk;

    // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, exmem_bubble}
    localparam logic [6:0] O_NORM  = 7'b1111_000;
    localparam logic [6:0] O_LU    = 7'b0011_010;
    localparam logic [6:0] O_REDIR = 7'b1111_110;
    localparam logic [6:0] O_MEMW  = 7'b0000_000;
    localparam logic [6:0] O_STK   = 7'b0001_001;
    localparam logic [6:0] O_RST   = 7'b0000_111;

    typedef struct {
        string      name;
        logic [4:0] rs_a;
        logic [4:0] rs_b;
        logic       a_used;
        logic       b_used;
        logic [4:0] dest;
        logic       mrd;
        logic       redir;
        logic       mreq;
        logic       mrdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic clr();
        bus.id_rs_a = '0; bus.id_rs_b = '0; bus.id_rs_a_used = 1'b0; bus.id_rs_b_used = 1'b0;
        bus.ex_dest = '0; bus.ex_mem_read = 1'b0; bus.ex_call = 1'b0; bus.ex_ret = 1'b0;
        bus.ex_redirect = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    endtask

    task automatic set_lu();
        bus.ex_mem_read = 1'b1; bus.ex_dest = 5'd5; bus.id_rs_b = 5'd5; bus.id_rs_b_used = 1'b1;
    endtask

    task automatic chk(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
               bus.ifid_flush, bus.idex_bubble, bus.exmem_bubble};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{"idle",        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[1]  = '{"lu_rs_b",     5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[2]  = '{"after_lu",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[3]  = '{"lu_dest0",    5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[4]  = '{"lu_rs_a",     5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[5]  = '{"lu_unused",   5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[6]  = '{"no_memread",  5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[7]  = '{"redir_lu",    5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_REDIR};
        vecs[8]  = '{"redir",       5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_REDIR};
        vecs[9]  = '{"mem_ready",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_NORM};
        vecs[10] = '{"memw_over_lu",5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, O_MEMW};
        vecs[11] = '{"memw_rdy_lu", 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, O_LU};
        vecs[12] = '{"idle_end",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM};

        clr();
        #1 chk("reset_outputs", O_RST);
        @(negedge clk);
        chk("reset_hold", O_RST);
        rst = 1'b0;
        #1 chk("post_reset", O_NORM);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            clr();
            bus.id_rs_a = vecs[i].rs_a; bus.id_rs_b = vecs[i].rs_b;
            bus.id_rs_a_used = vecs[i].a_used; bus.id_rs_b_used = vecs[i].b_used;
            bus.ex_dest = vecs[i].dest; bus.ex_mem_read = vecs[i].mrd;
            bus.ex_redirect = vecs[i].redir; bus.mem_req = vecs[i].mreq;
            bus.mem_ready = vecs[i].mrdy;
            #1 chk(vecs[i].name, vecs[i].exp);
        end

        // call: two stall cycles then release
        @(negedge clk); clr(); bus.ex_call = 1'b1;
        #1 chk("call_detect", O_STK);
        @(negedge clk); #1 chk("call_stall", O_STK);
        @(negedge clk); #1 chk("call_release", O_NORM);
        @(negedge clk); bus.ex_call = 1'b0;
        #1 chk("call_after", O_NORM);

        // ret: redirect on release cycle
        @(negedge clk); clr(); bus.ex_ret = 1'b1;
        #1 chk("ret_detect", O_STK);
        @(negedge clk); #1 chk("ret_stall", O_STK);
        @(negedge clk); #1 chk("ret_release", O_REDIR);
        @(negedge clk); bus.ex_ret = 1'b0;
        #1 chk("ret_after", O_NORM);

        // mem wait for 4 cycles, resume on mem_ready
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); clr(); bus.mem_req = 1'b1;
            #1 chk($sformatf("memwait_%0d", i), O_MEMW);
        end
        @(negedge clk); bus.mem_ready = 1'b1;
        #1 chk("memwait_resume", O_NORM);

        // mem wait during STACK freezes the stack count
        @(negedge clk); clr(); bus.ex_call = 1'b1;
        #1 chk("stkmem_detect", O_STK);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
            #1 chk($sformatf("stkmem_wait_%0d", i), O_MEMW);
        end
        @(negedge clk); bus.mem_ready = 1'b1;
        #1 chk("stkmem_resume", O_STK);
        @(negedge clk); bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
        #1 chk("stkmem_release", O_NORM);
        @(negedge clk); clr();
        #1 chk("stkmem_after", O_NORM);

        // async reset mid-STACK, then back in RUN
        @(negedge clk); clr(); bus.ex_call = 1'b1;
        #1 chk("rststk_detect", O_STK);
        @(negedge clk); #1 chk("rststk_stall", O_STK);
        rst = 1'b1;
        #1 chk("rststk_async", O_RST);
        @(negedge clk); clr(); rst = 1'b0;
        set_lu();
        #1 chk("rststk_run_lu", O_LU);
        @(negedge clk); clr();
        #1 chk("rststk_idle", O_NORM);

`ifdef PIPE_CTRL_PERF_EN
        @(negedge clk); rst = 1'b1;
        #1 rst = 1'b0;
        chk_val("perf_reset_stall", int'(stall_cycles), 0);
        chk_val("perf_reset_flush", int'(flush_count), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); clr(); set_lu();
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); clr(); bus.ex_redirect = 1'b1;
        end
        @(negedge clk); clr();
        chk_val("perf_stall_3", int'(stall_cycles), 3);
        chk_val("perf_flush_2", int'(flush_count), 2);
        set_lu();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); clr(); bus.ex_redirect = 1'b1;
        end
        @(negedge clk); clr();
        chk_val("perf_stall_sat", int'(stall_cycles), 3);
        chk_val("perf_flush_sat", int'(flush_count), 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
